// File: rtl/arm_pred_pkg.sv
// Shared types and helpers for the fetch-stage branch predictor.
// btb_entry_t describes the default 16-entry, 32-bit, 2-bit-counter configuration.
package arm_pred_pkg;

  localparam int ENTRIES_DEF = 16;
  localparam int ADDR_W_DEF  = 32;
  localparam int CTR_W_DEF   = 2;
  localparam int IDX_W_DEF   = $clog2(ENTRIES_DEF);
  localparam int TAG_W_DEF   = ADDR_W_DEF - IDX_W_DEF - 2;
  localparam int CTR_W_MAX   = 4;

  localparam int MODE_STATIC = 0;
  localparam int MODE_BTB    = 1;

  typedef struct packed {
    logic                  valid;
    logic [TAG_W_DEF-1:0]  tag;
    logic [ADDR_W_DEF-1:0] target;
    logic [CTR_W_DEF-1:0]  ctr;
  } btb_entry_t;

  // The counter is widened to CTR_W_MAX bits, so one function serves every counter width.
  function automatic logic [CTR_W_MAX-1:0] sat_update(input logic [CTR_W_MAX-1:0] ctr,
                                                      input logic taken,
                                                      input int width);
    logic [CTR_W_MAX-1:0] max_val;
    max_val = CTR_W_MAX'((1 << width) - 1);
    if (taken) begin
      return (ctr == max_val) ? ctr : ctr + 1'b1;
    end
    return (ctr == '0) ? ctr : ctr - 1'b1;
  endfunction

endpackage

// File: rtl/btb_predictor_if.sv
// Fetch, resolve and perf signals exchanged between the core and the branch predictor.
interface btb_predictor_if #(
  parameter int ADDR_W = 32,
  parameter int PERF_W = 16
);
  logic [ADDR_W-1:0] PCF;
  logic              PredTakenF;
  logic [ADDR_W-1:0] PredTargetF;
  logic              StallD;
  logic              FlushD;
  logic              FlushE;
  logic              BranchE;
  logic              BranchTakenE_for_predictor;
  logic [ADDR_W-1:0] BranchTargetE;
  logic              Correct_addr_prediction;
  logic              RecoverE;
  logic [ADDR_W-1:0] RecoverPCE;
  logic [PERF_W-1:0] LookupsCnt;
  logic [PERF_W-1:0] MispredCnt;

  modport master (
    output PCF, StallD, FlushD, FlushE, BranchE, BranchTakenE_for_predictor, BranchTargetE,
    input  PredTakenF, PredTargetF, Correct_addr_prediction, RecoverE, RecoverPCE,
           LookupsCnt, MispredCnt
  );

  modport slave (
    input  PCF, StallD, FlushD, FlushE, BranchE, BranchTakenE_for_predictor, BranchTargetE,
    output PredTakenF, PredTargetF, Correct_addr_prediction, RecoverE, RecoverPCE,
           LookupsCnt, MispredCnt
  );
endinterface

// File: rtl/sat_counter.sv
// Next-state logic for a CTR_W-bit saturating up/down direction counter.
module sat_counter
  import arm_pred_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr,
  input  logic             taken,
  output logic [CTR_W-1:0] ctr_next
);

  assign ctr_next = CTR_W'(sat_update(CTR_W_MAX'(ctr), taken, CTR_W));

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with saturating-counter direction prediction.
// Predictions travel with the instruction through D and E and are checked against the resolved branch in E.
module btb_predictor
  import arm_pred_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 32,
  parameter int CTR_W   = 2,
  parameter int MODE    = MODE_BTB,
  parameter int PERF_W  = 16
) (
  input  logic      clk,
  input  logic      reset,
  btb_predictor_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
    logic [CTR_W-1:0]  ctr;
  } entry_t;

  entry_t tbl [ENTRIES];

  logic [IDX_W-1:0]  idx_f;
  logic [IDX_W-1:0]  idx_e;
  logic [TAG_W-1:0]  tag_f;
  logic [TAG_W-1:0]  tag_e;
  entry_t            ent_f;
  entry_t            ent_e;
  logic              hit_f;
  logic              hit_e;
  logic              pred_f;
  logic [ADDR_W-1:0] pred_target_f;

  logic              pred_d;
  logic [ADDR_W-1:0] target_d;
  logic [ADDR_W-1:0] pc_d;
  logic              pred_e;
  logic [ADDR_W-1:0] target_e;
  logic [ADDR_W-1:0] pc_e;

  logic              taken_e;
  logic              target_ok_e;
  logic              mispred_e;
  logic              update_en;
  logic [CTR_W-1:0]  ctr_next;
  logic [PERF_W-1:0] lookups;
  logic [PERF_W-1:0] mispreds;
  logic              unused_pc_bits;

  assign idx_f          = bus.PCF[IDX_W+1:2];
  assign tag_f          = bus.PCF[ADDR_W-1:IDX_W+2];
  assign idx_e          = pc_e[IDX_W+1:2];
  assign tag_e          = pc_e[ADDR_W-1:IDX_W+2];
  assign unused_pc_bits = ^bus.PCF[1:0];

  // Fetch lookup reads the table as it stands this cycle; a same-cycle update is not forwarded.
  always_comb begin
    ent_f         = tbl[idx_f];
    hit_f         = ent_f.valid && (ent_f.tag == tag_f);
    pred_f        = (MODE == MODE_BTB) && hit_f && ent_f.ctr[CTR_W-1];
    pred_target_f = pred_f ? ent_f.target : '0;
  end

  assign bus.PredTakenF  = pred_f;
  assign bus.PredTargetF = pred_target_f;

  always_ff @(posedge clk) begin
    if (!reset || bus.FlushD) begin
      pred_d   <= 1'b0;
      target_d <= '0;
      pc_d     <= '0;
    end else if (!bus.StallD) begin
      pred_d   <= pred_f;
      target_d <= pred_target_f;
      pc_d     <= bus.PCF;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || bus.FlushE) begin
      pred_e   <= 1'b0;
      target_e <= '0;
      pc_e     <= '0;
    end else begin
      pred_e   <= pred_d;
      target_e <= target_d;
      pc_e     <= pc_d;
    end
  end

  always_comb begin
    ent_e       = tbl[idx_e];
    hit_e       = ent_e.valid && (ent_e.tag == tag_e);
    taken_e     = bus.BranchE && bus.BranchTakenE_for_predictor;
    target_ok_e = (target_e == bus.BranchTargetE);
    mispred_e   = (pred_e ^ bus.BranchTakenE_for_predictor) ||
                  (pred_e && bus.BranchTakenE_for_predictor && !target_ok_e);
    update_en   = bus.BranchE && (MODE == MODE_BTB);
  end

  // A wrong-target taken prediction raises neither flag; the controller's BranchTakenE redirect covers it.
  assign bus.Correct_addr_prediction = pred_e && taken_e && target_ok_e;
  assign bus.RecoverE                = pred_e && !taken_e;
  assign bus.RecoverPCE              = pc_e + ADDR_W'(4);

  sat_counter #(.CTR_W(CTR_W)) u_sat_counter (
    .ctr      (ent_e.ctr),
    .taken    (bus.BranchTakenE_for_predictor),
    .ctr_next (ctr_next)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i] <= '0;
      end
    end else if (update_en) begin
      if (hit_e) begin
        tbl[idx_e].ctr <= ctr_next;
        if (bus.BranchTakenE_for_predictor) begin
          tbl[idx_e].target <= bus.BranchTargetE;
        end
      end else if (bus.BranchTakenE_for_predictor) begin
        tbl[idx_e] <= '{valid: 1'b1, tag: tag_e, target: bus.BranchTargetE, ctr: CTR_WEAK};
      end
    end
  end

  // Perf counters run in every mode and wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lookups  <= '0;
      mispreds <= '0;
    end else if (bus.BranchE) begin
      lookups <= lookups + PERF_W'(1);
      if (mispred_e) begin
        mispreds <= mispreds + PERF_W'(1);
      end
    end
  end

  assign bus.LookupsCnt = lookups;
  assign bus.MispredCnt = mispreds;

endmodule

// File: tb/tb_btb_predictor.sv
// Scoreboard bench for btb_predictor: directed branch sequences push expected values tagged with
// a cycle number, and a negedge monitor pops and compares them. A MODE_STATIC copy shadows the inputs.
module tb_btb_predictor;
  import arm_pred_pkg::*;

  localparam int ADDR_W = 32;
  localparam int PERF_W = 16;
  localparam logic [31:0] FILLER = 32'h0000_0504;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  btb_predictor_if #(.ADDR_W(ADDR_W), .PERF_W(PERF_W)) bus ();
  btb_predictor_if #(.ADDR_W(ADDR_W), .PERF_W(PERF_W)) bus_s ();

  btb_predictor #(
    .ENTRIES(16), .ADDR_W(ADDR_W), .CTR_W(2), .MODE(MODE_BTB), .PERF_W(PERF_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  btb_predictor #(
    .ENTRIES(16), .ADDR_W(ADDR_W), .CTR_W(2), .MODE(MODE_STATIC), .PERF_W(PERF_W)
  ) dut_static (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  assign bus_s.PCF                        = bus.PCF;
  assign bus_s.StallD                     = bus.StallD;
  assign bus_s.FlushD                     = bus.FlushD;
  assign bus_s.FlushE                     = bus.FlushE;
  assign bus_s.BranchE                    = bus.BranchE;
  assign bus_s.BranchTakenE_for_predictor = bus.BranchTakenE_for_predictor;
  assign bus_s.BranchTargetE              = bus.BranchTargetE;

  typedef struct {
    int          cyc;
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] probe(input int sel);
    case (sel)
      0:       return 32'(bus.PredTakenF);
      1:       return bus.PredTargetF;
      2:       return 32'(bus.Correct_addr_prediction);
      3:       return 32'(bus.RecoverE);
      4:       return bus.RecoverPCE;
      5:       return 32'(bus.LookupsCnt);
      6:       return 32'(bus.MispredCnt);
      7:       return 32'(bus_s.PredTakenF);
      8:       return 32'(bus_s.LookupsCnt);
      9:       return 32'(bus_s.MispredCnt);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: pops every expectation due this cycle; anything overdue counts as an error.
  always @(negedge clk) begin : monitor
    exp_t        item;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      item = sb.pop_front();
      checks++;
      if (item.cyc != cyc) begin
        errors++;
        $display("[TB] FAIL %s: expectation for cycle %0d sampled at cycle %0d", item.name, item.cyc, cyc);
      end else begin
        act = probe(item.sel);
        if (act !== item.exp) begin
          errors++;
          $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", item.name, act, item.exp, cyc);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] pcf, input logic br, input logic tk,
                               input logic [31:0] tgt, input logic stall,
                               input logic flush_d, input logic flush_e);
    bus.PCF                        = pcf;
    bus.BranchE                    = br;
    bus.BranchTakenE_for_predictor = tk;
    bus.BranchTargetE              = tgt;
    bus.StallD                     = stall;
    bus.FlushD                     = flush_d;
    bus.FlushE                     = flush_e;
  endtask

  task automatic checkOutput(input string name, input int sel, input logic [31:0] exp);
    exp_t item;
    item.cyc  = cyc;
    item.name = name;
    item.sel  = sel;
    item.exp  = exp;
    sb.push_back(item);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Fetch pc, two filler cycles later resolve it in E; counters are checked before this op's update.
  task automatic branch_op(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic exp_pred, input logic [31:0] exp_tgt,
                           input logic exp_corr, input logic exp_rec,
                           input int exp_look, input int exp_misp,
                           input logic same_fetch, input logic exp_same_pred);
    applyStimulus(pc, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("pred_taken", 0, 32'(exp_pred));
    checkOutput("pred_target", 1, exp_tgt);
    checkOutput("lookups", 5, exp_look);
    checkOutput("mispred", 6, exp_misp);
    checkOutput("static_pred_taken", 7, 32'h0);
    next_cycle();
    applyStimulus(FILLER, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    applyStimulus(same_fetch ? pc : FILLER, 1'b1, tk, tgt, 1'b0, 1'b0, 1'b0);
    checkOutput("correct_addr", 2, 32'(exp_corr));
    checkOutput("recover", 3, 32'(exp_rec));
    checkOutput("recover_pc", 4, pc + 32'd4);
    if (same_fetch) checkOutput("same_cycle_pred", 0, 32'(exp_same_pred));
    next_cycle();
  endtask

  initial begin
    applyStimulus(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    applyStimulus(32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_pred_taken", 0, 32'h0);
    checkOutput("reset_pred_target", 1, 32'h0);
    checkOutput("reset_correct", 2, 32'h0);
    checkOutput("reset_recover", 3, 32'h0);
    checkOutput("reset_recover_pc", 4, 32'h4);
    checkOutput("reset_lookups", 5, 32'h0);
    checkOutput("reset_mispred", 6, 32'h0);
    next_cycle();

    //        pc      tk  target   pred tgt      cor  rec  L   M   same exp_same
    branch_op(32'h40, 1, 32'h100, 0, 32'h000, 0, 0, 0,  0, 0, 0);  // miss, allocate ctr=2
    branch_op(32'h40, 1, 32'h100, 1, 32'h100, 1, 0, 1,  1, 0, 0);  // ctr 2->3
    branch_op(32'h40, 0, 32'h000, 1, 32'h100, 0, 1, 2,  1, 0, 0);  // ctr 3->2
    branch_op(32'h40, 0, 32'h000, 1, 32'h100, 0, 1, 3,  2, 0, 0);  // ctr 2->1
    branch_op(32'h40, 0, 32'h000, 0, 32'h000, 0, 0, 4,  3, 0, 0);  // ctr 1->0
    branch_op(32'h40, 0, 32'h000, 0, 32'h000, 0, 0, 5,  3, 0, 0);  // saturates at 0
    branch_op(32'h40, 1, 32'h100, 0, 32'h000, 0, 0, 6,  3, 0, 0);  // ctr 0->1
    branch_op(32'h40, 1, 32'h100, 0, 32'h000, 0, 0, 7,  4, 0, 0);  // ctr 1->2
    branch_op(32'h40, 1, 32'h200, 1, 32'h100, 0, 0, 8,  5, 0, 0);  // wrong target
    branch_op(32'h40, 1, 32'h200, 1, 32'h200, 1, 0, 9,  6, 0, 0);  // retargeted
    branch_op(32'h80, 1, 32'h300, 0, 32'h000, 0, 0, 10, 6, 0, 0);  // alias evicts 0x40
    branch_op(32'h40, 0, 32'h000, 0, 32'h000, 0, 0, 11, 7, 0, 0);  // 0x40 now misses
    branch_op(32'h80, 1, 32'h300, 1, 32'h300, 1, 0, 12, 7, 0, 0);  // 0x80 entry intact
    branch_op(32'hC0, 1, 32'h400, 0, 32'h000, 0, 0, 13, 7, 1, 0);  // same-cycle lookup sees old entry
    branch_op(32'hC0, 1, 32'h400, 1, 32'h400, 1, 0, 14, 8, 0, 0);

    // StallD holds the D prediction while FlushE drops the one in E.
    applyStimulus(32'hC0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("stall_fetch_pred", 0, 32'h1);
    next_cycle();
    applyStimulus(FILLER, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    next_cycle();
    applyStimulus(FILLER, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("flushe_recover", 3, 32'h0);
    checkOutput("flushe_recover_pc", 4, 32'h4);
    checkOutput("flushe_correct", 2, 32'h0);
    next_cycle();
    applyStimulus(FILLER, 1'b1, 1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
    checkOutput("stall_held_correct", 2, 32'h1);
    checkOutput("stall_held_recover_pc", 4, 32'hC4);
    next_cycle();
    applyStimulus(FILLER, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("lookups_after_stall", 5, 32'd16);
    checkOutput("mispred_after_stall", 6, 32'd8);
    checkOutput("static_lookups", 8, 32'd16);
    checkOutput("static_mispred", 9, 32'd11);
    next_cycle();

    // FlushD wins over StallD.
    applyStimulus(32'hC0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    next_cycle();
    applyStimulus(FILLER, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    applyStimulus(FILLER, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("flushd_recover_pc", 4, 32'h4);
    checkOutput("flushd_recover", 3, 32'h0);
    next_cycle();

    // Reset on the same edge as a taken update cancels the update.
    applyStimulus(32'hC0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_reset_pred", 0, 32'h1);
    next_cycle();
    applyStimulus(FILLER, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    applyStimulus(FILLER, 1'b1, 1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    applyStimulus(32'hC0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_reset_pred", 0, 32'h0);
    checkOutput("post_reset_target", 1, 32'h0);
    checkOutput("post_reset_lookups", 5, 32'h0);
    checkOutput("post_reset_mispred", 6, 32'h0);
    checkOutput("post_reset_correct", 2, 32'h0);
    checkOutput("post_reset_recover", 3, 32'h0);
    checkOutput("post_reset_static_lookups", 8, 32'h0);
    next_cycle();

    for (int i = 0; i < 5 && sb.size() > 0; i++) next_cycle();
    if (sb.size() > 0) begin
      errors += sb.size();
      checks += sb.size();
      $display("[TB] FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
